// File: rtl/ws2812b_frame_streamer_if.sv
// AXI-Stream pixel channel between the frame streamer and the WS2812B serializer.
interface ws2812b_frame_streamer_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/ws2812b_frame_streamer.sv
// Streams one frame of GRB pixels from an internal RAM over AXI-Stream, then holds the latch gap.
// Optional global brightness scaling is built when WS2812B_BRIGHTNESS_EN is defined.
module ws2812b_frame_streamer #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned LATCH_CYCLES = 3600
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  input  logic [7:0]            brightness,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  ws2812b_frame_streamer_if.master m_axis
);

  localparam int unsigned CntW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [ADDR_WIDTH:0]   NumLeds  = (ADDR_WIDTH + 1)'(NUM_LEDS);
  localparam logic [CntW-1:0]       LastCnt  = CntW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StLatch} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  start_q;
  logic [23:0]           tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  done_q, done_d;
  logic [23:0]           rd_data_q;
  logic [23:0]           pixel;

  logic [23:0] mem [NUM_LEDS];

  // Read port always samples; data is only consumed in FETCH, one cycle after the address.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en && ({1'b0, wr_addr} < NumLeds)) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0] bright_q, bright_d;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'({1'b0, b} + 9'd1);
    return 8'(p >> 8);
  endfunction

  always_comb begin
    pixel = {scale_ch(rd_data_q[23:16], bright_q),
             scale_ch(rd_data_q[15:8], bright_q),
             scale_ch(rd_data_q[7:0], bright_q)};
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      bright_q <= 8'd255;
    end else begin
      bright_q <= bright_d;
    end
  end

  always_comb begin
    bright_d = bright_q;
    if (state_q == StIdle && (start_q || pending_q)) begin
      bright_d = brightness;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pixel = rd_data_q;
`endif

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      tdata_q   <= 24'h000000;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      start_q   <= start;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
    rd_addr   = idx_q;

    // Requests arriving mid-frame collapse into one queued frame.
    if (start_q && state_q != StIdle) begin
      pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_q || pending_q) begin
          pending_d = 1'b0;
          idx_d     = '0;
          rd_addr   = '0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        tdata_d  = pixel;
        tvalid_d = 1'b1;
        tlast_d  = (idx_q == LastIdx);
        state_d  = StSend;
      end
      StSend: begin
        if (m_axis.tready) begin
          tvalid_d = 1'b0;
          if (idx_q == LastIdx) begin
            tlast_d = 1'b0;
            cnt_d   = '0;
            state_d = StLatch;
          end else begin
            idx_d   = idx_q + 1'b1;
            rd_addr = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StLatch: begin
        if (cnt_q == LastCnt) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Directed bench for ws2812b_frame_streamer: expected beats are queued at stimulus time and
// popped by a handshake monitor. Brightness frames are exercised when WS2812B_BRIGHTNESS_EN is set.
module tb_ws2812b_frame_streamer;
  localparam int N = 8;
  localparam int L = 3600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [7:0]  brightness = 8'd255;
  logic        start = 1'b0;
  logic        busy;
  logic        done;

  ws2812b_frame_streamer_if axis ();

  ws2812b_frame_streamer #(
    .NUM_LEDS    (N),
    .ADDR_WIDTH  (3),
    .LATCH_CYCLES(L)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .brightness    (brightness),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .m_axis        (axis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [23:0] pix[N];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats = 0;
  int          last_hs_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_d = '0;
  logic        prev_l = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] p, input int b);
`ifdef WS2812B_BRIGHTNESS_EN
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (b + 1)) >> 8);
    return r;
`else
    return (b >= 0) ? p : p;
`endif
  endfunction

  // Handshake monitor: pops the scoreboard and checks that stalled beats hold still.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", axis.tvalid, 1);
        check("stall_data", axis.tdata, prev_d);
        check("stall_last", axis.tlast, prev_l);
      end
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed %0h expected none", axis.tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", axis.tdata, e.d);
          check("beat_last", axis.tlast, e.l);
        end
        beats++;
        last_hs_cyc = cyc;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_d     = axis.tdata;
      prev_l     = axis.tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    logic [2:0] a3;
    a3      = a[2:0];
    wr_en   = 1'b1;
    wr_addr = a3;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    pix[a]  = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame(input int b);
    for (int i = 0; i < N; i++) exp_q.push_back('{d: scale(pix[i], b), l: (i == N - 1)});
  endtask

  task automatic wait_send(input int n, input string tag);
    int k;
    k = 0;
    while (!(axis.tvalid && beats == n) && k < 200) begin
      tick();
      k++;
    end
    check(tag, (axis.tvalid && beats == n), 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 5000) begin
      tick();
      k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int b0;
    axis.tready = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tdata", axis.tdata, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Frame 1: ramp pattern, tready held high, latency and frame length.
    for (int i = 0; i < N; i++) wr(i, 24'(i + 1));
    push_frame(255);
    pulse_start();
    c0 = cyc;
    check("e0_busy", busy, 0);
    check("e0_tvalid", axis.tvalid, 0);
    tick();
    check("e1_busy", busy, 1);
    check("e1_tvalid", axis.tvalid, 0);
    tick();
    check("e2_tvalid", axis.tvalid, 1);
    check("e2_tdata", axis.tdata, 24'h000001);
    wait_done("f1_done");
    check("f1_len", cyc - c0, 2 + 2 * N - 1 + L);
    check("f1_latch", cyc - (last_hs_cyc + 1), L);
    check("f1_busy_at_done", busy, 0);

    // Frame 2: mid-frame writes, backpressure, two merged start requests.
    b0 = beats;
    pix[5] = 24'hABCDEF;
    push_frame(255);
    pulse_start();
    wait_send(b0, "f2_beat0");
    wr(0, 24'h123456);
    wait_send(b0 + 1, "f2_beat1");
    wr(5, 24'hABCDEF);
    wait_send(b0 + 2, "f2_beat2");
    pulse_start();
    wait_send(b0 + 3, "f2_beat3");
    axis.tready = 1'b0;
    repeat (10) tick();
    check("bp_no_transfer", beats, b0 + 3);
    axis.tready = 1'b1;
    pulse_start();
    push_frame(255);
    wait_done("f2_done");
    check("f2_busy_at_done", busy, 0);
    tick();
    check("pend_fetch_busy", busy, 1);
    check("pend_fetch_tvalid", axis.tvalid, 0);
    tick();
    check("pend_send_tvalid", axis.tvalid, 1);
    check("pend_send_tdata", axis.tdata, 24'h123456);
    wait_done("f3_done");
    repeat (20) tick();
    check("single_pending", busy, 0);
    check("beat_total", beats, 3 * N);
    check("queue_empty", exp_q.size(), 0);

    // Async reset mid-frame with a queued request: both must be dropped.
    b0 = beats;
    push_frame(255);
    pulse_start();
    wait_send(b0 + 2, "ar_beat2");
    pulse_start();
    wait_send(b0 + 3, "ar_beat3");
    rst_n = 1'b0;
    #1;
    check("ar_tvalid", axis.tvalid, 0);
    check("ar_busy", busy, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("ar_no_replay", beats, b0 + 3);
    check("ar_pending_lost", busy, 0);

`ifdef WS2812B_BRIGHTNESS_EN
    // Brightness is captured per frame; a mid-frame change waits for the next frame.
    wr(0, 24'hFF8040);
    brightness = 8'd127;
    b0 = beats;
    exp_q.push_back('{d: 24'h7F4020, l: 1'b0});
    for (int i = 1; i < N; i++) exp_q.push_back('{d: scale(pix[i], 127), l: (i == N - 1)});
    pulse_start();
    wait_send(b0 + 1, "br_beat1");
    brightness = 8'd255;
    wait_done("br127_done");
    exp_q.push_back('{d: 24'hFF8040, l: 1'b0});
    for (int i = 1; i < N; i++) exp_q.push_back('{d: pix[i], l: (i == N - 1)});
    pulse_start();
    wait_done("br255_done");
    check("br_beats", beats, b0 + 2 * N);
    check("br_queue_empty", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
